// File: rtl/prbs_seq_ctrl.sv
// Sequencing controller for a PRBS9 generator pair: reseeds, paces symbol
// strobes at OS_FACTOR clocks per symbol, and runs continuous or burst/gap patterns.
module prbs_seq_ctrl #(
  parameter int OS_FACTOR = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic [CNT_W-1:0] i_gap_len,
  input  logic             i_ready,
  output logic             o_prbs_reset,
  output logic             o_enable,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_period,
  output logic [CNT_W-1:0] o_sym_count,
  output logic [1:0]       o_state
);

  localparam int              PH_W    = $clog2(OS_FACTOR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_FACTOR - 1);
  localparam logic [8:0]      PER_LAST = 9'd510;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [8:0]       period_q, period_d;
  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic             prbs_reset_q, prbs_reset_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;

  logic sym_fire;
  logic phase_last;
  logic burst_done;
  logic gap_done;

  assign phase_last = (phase_q == PH_LAST);
  assign sym_fire   = (state_q == RUN) && phase_last && i_ready && !i_stop;
  // burst_len_q is never 0 (a zero request is latched as 1)
  assign burst_done = mode_q && (burst_cnt_q == burst_len_q - CNT_W'(1));
  assign gap_done   = phase_last && (gap_cnt_q == gap_len_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    period_d    = period_q;
    sym_count_d = sym_count_q;
    mode_d      = mode_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;

    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) state_d = SEED;
      end

      SEED: begin
        if (i_stop) begin
          state_d = IDLE;
        end else begin
          state_d     = RUN;
          mode_d      = i_mode;
          burst_len_d = (i_burst_len == '0) ? CNT_W'(1) : i_burst_len;
          gap_len_d   = i_gap_len;
          phase_d     = '0;
          burst_cnt_d = '0;
          gap_cnt_d   = '0;
          period_d    = '0;
          sym_count_d = '0;
        end
      end

      RUN: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (i_ready) begin
          if (phase_last) begin
            phase_d     = '0;
            sym_count_d = sym_count_q + CNT_W'(1);
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            period_d    = (period_q == PER_LAST) ? 9'd0 : period_q + 9'd1;
            if (burst_done) begin
              burst_cnt_d = '0;
              gap_cnt_d   = '0;
              if (gap_len_q != '0) state_d = GAP;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      GAP: begin
        // Gap timing is free-running: downstream back-pressure does not stretch it
        if (i_stop) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_last ? '0 : phase_q + PH_W'(1);
          if (gap_done) begin
            state_d     = RUN;
            gap_cnt_d   = '0;
            burst_cnt_d = '0;
          end else if (phase_last) begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    prbs_reset_d = (state_d == SEED);
    enable_d     = (state_d == RUN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      period_q     <= '0;
      sym_count_q  <= '0;
      mode_q       <= 1'b0;
      burst_len_q  <= CNT_W'(1);
      gap_len_q    <= '0;
      prbs_reset_q <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      period_q     <= period_d;
      sym_count_q  <= sym_count_d;
      mode_q       <= mode_d;
      burst_len_q  <= burst_len_d;
      gap_len_q    <= gap_len_d;
      prbs_reset_q <= prbs_reset_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
    end
  end

  assign o_prbs_reset = prbs_reset_q;
  assign o_enable     = enable_q;
  assign o_busy       = busy_q;
  assign o_valid      = sym_fire;
  assign o_period     = sym_fire && (period_q == PER_LAST);
  assign o_sym_count  = sym_count_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl; cycle c is the interval after the edge that
// sampled i_start (cycle 1 is the reseed cycle).
module tb_prbs_seq_ctrl;

  localparam int OS = 4;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_mode = 1'b0;
  logic [CW-1:0] i_burst_len = '0;
  logic [CW-1:0] i_gap_len = '0;
  logic          i_ready = 1'b1;
  logic          o_prbs_reset, o_enable, o_valid, o_busy, o_period;
  logic [CW-1:0] o_sym_count;
  logic [1:0]    o_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clock = ~clock;

  prbs_seq_ctrl #(.OS_FACTOR(OS), .CNT_W(CW)) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_burst_len(i_burst_len), .i_gap_len(i_gap_len),
    .i_ready(i_ready), .o_prbs_reset(o_prbs_reset), .o_enable(o_enable),
    .o_valid(o_valid), .o_busy(o_busy), .o_period(o_period),
    .o_sym_count(o_sym_count), .o_state(o_state)
  );

  // Reference timing with i_ready held high: returns {enable, valid} for cycle c
  function automatic logic [1:0] model_ev(int c, int len, int gap, bit burst);
    int o;
    int per;
    logic en;
    if (c < 2) return 2'b00;
    if (!burst) return {1'b1, ((c - 2) % OS) == OS - 1};
    per = (len + gap) * OS;
    o   = (c - 2) % per;
    en  = (o < len * OS);
    return {en, en && ((o % OS) == OS - 1)};
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  task automatic stop_seq();
    i_stop = 1'b1;
    @(posedge clock); #1;
    i_stop = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    check_cnt++;
    if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period, o_sym_count, o_state} !== '0)
      $display("FAIL reset_outs got=%b/%0d/%0d exp=00000/0/0",
               {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, o_sym_count, o_state);
    else pass_cnt++;
    @(negedge clock); i_reset_n = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check_cnt++;
      if ({o_busy, o_enable, o_state} !== 4'b0000)
        $display("FAIL reset_idle c=%0d got=%b exp=0000", c, {o_busy, o_enable, o_state});
      else pass_cnt++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_continuous();
    logic [1:0] ev;
    logic [4:0] exp;
    int exp_sym = 0;
    i_mode = 1'b0; i_burst_len = 16'd2; i_gap_len = 16'd5;
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      ev  = model_ev(c, 0, 0, 1'b0);
      exp = {c == 1, ev[1], ev[0], 1'b1, 1'b0};
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL cont_outs c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      if (c >= 2) begin
        check_cnt++;
        if (o_sym_count !== CW'(exp_sym))
          $display("FAIL cont_sym c=%0d got=%0d exp=%0d", c, o_sym_count, exp_sym);
        else pass_cnt++;
      end
      if (ev[0]) exp_sym++;
      @(posedge clock); #1;
    end
    stop_seq();
  endtask

  task automatic test_burst();
    logic [1:0] ev;
    logic [4:0] exp;
    int exp_sym = 0;
    i_mode = 1'b1; i_burst_len = 16'd3; i_gap_len = 16'd2;
    pulse_start();
    for (int c = 1; c <= 47; c++) begin
      // Config changes after the reseed must not affect the running sequence
      if (c == 3) begin i_burst_len = 16'd5; i_gap_len = 16'd0; i_mode = 1'b0; end
      ev  = model_ev(c, 3, 2, 1'b1);
      exp = {c == 1, ev[1], ev[0], 1'b1, 1'b0};
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL burst_outs c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      if (c >= 2) begin
        check_cnt++;
        if (o_sym_count !== CW'(exp_sym))
          $display("FAIL burst_sym c=%0d got=%0d exp=%0d", c, o_sym_count, exp_sym);
        else pass_cnt++;
      end
      if (ev[0]) exp_sym++;
      @(posedge clock); #1;
    end
    stop_seq();
  endtask

  task automatic test_zero_len();
    logic [1:0] ev;
    logic [4:0] exp;
    i_mode = 1'b1; i_burst_len = 16'd0; i_gap_len = 16'd0;
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      ev  = model_ev(c, 0, 0, 1'b0);
      exp = {c == 1, ev[1], ev[0], 1'b1, 1'b0};
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL zero_len c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    stop_seq();
  endtask

  task automatic test_ready();
    logic       exp_v;
    logic [4:0] exp;
    i_mode = 1'b0;
    pulse_start();
    for (int c = 1; c <= 23; c++) begin
      i_ready = !(c >= 11 && c <= 15);
      i_start = (c == 7);
      exp_v = (c == 5) || (c == 9) || (c == 18) || (c == 22);
      exp   = {c == 1, c >= 2, exp_v, 1'b1, 1'b0};
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL ready_outs c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    i_ready = 1'b1; i_start = 1'b0;
    check_cnt++;
    if (o_sym_count !== CW'(4))
      $display("FAIL ready_sym got=%0d exp=4", o_sym_count);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_stop_valid();
    logic [4:0] exp;
    i_mode = 1'b0;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      i_stop = (c == 5);
      exp = (c == 1) ? 5'b10010 : (c <= 5) ? 5'b01010 : 5'b00000;
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL stop_valid c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    check_cnt++;
    if (o_sym_count !== CW'(0) || o_state !== 2'd0)
      $display("FAIL stop_valid_end got=%0d/%0d exp=0/0", o_sym_count, o_state);
    else pass_cnt++;
  endtask

  task automatic test_stop_gap();
    logic [1:0] ev;
    logic [4:0] exp;
    i_mode = 1'b1; i_burst_len = 16'd2; i_gap_len = 16'd3;
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      i_stop  = (c == 12) || (c == 14);
      i_start = (c == 14);
      ev  = model_ev(c, 2, 3, 1'b1);
      exp = (c <= 12) ? {c == 1, ev[1], ev[0], 1'b1, 1'b0} : 5'b00000;
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL stop_gap c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      if (c >= 13) begin
        check_cnt++;
        if (o_sym_count !== CW'(2) || o_state !== 2'd0)
          $display("FAIL stop_gap_hold c=%0d got=%0d/%0d exp=2/0", c, o_sym_count, o_state);
        else pass_cnt++;
      end
      @(posedge clock); #1;
    end
    i_stop = 1'b0; i_start = 1'b0;
  endtask

  task automatic test_period();
    logic [1:0] ev;
    logic [4:0] exp;
    int exp_sym = 0;
    i_mode = 1'b0;
    pulse_start();
    for (int c = 1; c <= 4090; c++) begin
      ev  = model_ev(c, 0, 0, 1'b0);
      exp = {c == 1, ev[1], ev[0], 1'b1, ev[0] && ((exp_sym + 1) % 511 == 0)};
      @(negedge clock);
      check_cnt++;
      if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period} !== exp)
        $display("FAIL period_outs c=%0d got=%b exp=%b", c, {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, exp);
      else pass_cnt++;
      if (ev[0]) exp_sym++;
      @(posedge clock); #1;
    end
    check_cnt++;
    if (o_sym_count !== CW'(1022) || exp_sym != 1022)
      $display("FAIL period_sym got=%0d exp=1022", o_sym_count);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_async_reset();
    i_mode = 1'b0;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check_cnt++;
    if ({o_enable, o_valid, o_busy, o_sym_count} !== {3'b111, CW'(1)})
      $display("FAIL areset_pre got=%b/%0d exp=111/1", {o_enable, o_valid, o_busy}, o_sym_count);
    else pass_cnt++;
    #1 i_reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({o_prbs_reset, o_enable, o_valid, o_busy, o_period, o_sym_count, o_state} !== '0)
      $display("FAIL areset_now got=%b/%0d/%0d exp=00000/0/0",
               {o_prbs_reset, o_enable, o_valid, o_busy, o_period}, o_sym_count, o_state);
    else pass_cnt++;
    @(posedge clock);
    @(negedge clock); i_reset_n = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_cnt++;
      if ({o_busy, o_enable, o_state} !== 4'b0000)
        $display("FAIL areset_idle c=%0d got=%b exp=0000", c, {o_busy, o_enable, o_state});
      else pass_cnt++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_zero_len();
    test_ready();
    test_stop_valid();
    test_stop_gap();
    test_period();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/prbs_seq_ctrl.md
PRBS_SEQ_CTRL -- requirements
Module: prbs_seq_ctrl

Interface
REQ-001 SHALL have parameter OS_FACTOR, default 4, clock cycles per symbol (>=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the length and symbol counters.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  one-cycle request to begin a sequence.
REQ-006 SHALL have port i_stop  input  1  one-cycle request to abort to idle.
REQ-007 SHALL have port i_mode  input  1  0 = continuous, 1 = burst.
REQ-008 SHALL have port i_burst_len  input  CNT_W  symbols per burst; 0 treated as 1.
REQ-009 SHALL have port i_gap_len  input  CNT_W  idle symbol periods between bursts.
REQ-010 SHALL have port i_ready  input  1  downstream ready; low freezes symbol timing in RUN.
REQ-011 SHALL have port o_prbs_reset  output  1  active-high reseed pulse to the PRBS generators.
REQ-012 SHALL have port o_enable  output  1  PRBS enable level.
REQ-013 SHALL have port o_valid  output  1  one-cycle symbol strobe (PRBS advance).
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port o_period  output  1  pulse marking completion of each 511-symbol PRBS9 period.
REQ-016 SHALL have port o_sym_count  output  CNT_W  symbols issued since last reseed.

Function
REQ-017 SHALL implement FSM states IDLE, SEED, RUN, GAP, with Moore decode of o_prbs_reset (SEED only), o_enable (RUN only) and o_busy (not IDLE).
REQ-018 IDLE: i_start=1 and i_stop=0 at an edge -> SEED; otherwise stay; outputs low, counters held.
REQ-019 SEED: lasts exactly one cycle; latches i_mode, i_burst_len, i_gap_len; clears phase, burst, gap, period counters and o_sym_count; -> RUN.
REQ-020 RUN: phase counter counts 0..OS_FACTOR-1 only while i_ready=1; o_valid=1 combinationally when phase==OS_FACTOR-1 and i_ready=1 and i_stop=0.
REQ-021 Each o_valid SHALL increment o_sym_count (wraps 2^CNT_W-1 -> 0), the burst counter, and the period counter (0..510, wraps to 0).
REQ-022 o_period SHALL be high in the same cycle as the 511th, 1022nd, ... o_valid after SEED.
REQ-023 Burst mode: o_valid that completes the latched burst length -> GAP, or -> RUN with burst counter cleared if latched gap length is 0.
REQ-024 Continuous mode: RUN persists until i_stop.
REQ-025 GAP: counts latched gap_len*OS_FACTOR cycles regardless of i_ready, then -> RUN with phase 0 and burst counter cleared; no reseed (PRBS stream continues across bursts).
REQ-026 i_stop=1 in SEED, RUN or GAP -> IDLE at next edge; o_valid suppressed in that cycle; i_stop has priority over i_start and over all other transitions.
REQ-027 i_start in SEED, RUN or GAP SHALL be ignored; changes to i_mode, i_burst_len, i_gap_len take effect only at the next SEED.
REQ-028 Latency: i_start sampled at edge k -> o_prbs_reset high cycle k+1 -> o_enable high from cycle k+2 -> first o_valid at cycle k+1+OS_FACTOR (i_ready=1).

Reset
REQ-029 i_reset_n=0 SHALL immediately force IDLE and all outputs and counters to 0, without waiting for a clock edge.
REQ-030 Deassertion SHALL take effect at the first rising edge with i_reset_n=1; no sequence starts without a new i_start.

Verification
REQ-031 OS=4, continuous, i_start at edge 0 -> o_prbs_reset cycle 1; o_enable from cycle 2; o_valid cycles 5, 9, 13...; o_sym_count 1, 2, 3.
REQ-032 Burst, len=3, gap=2 -> 3 valids 4 cycles apart; o_enable low 8 cycles; 3 more valids; o_prbs_reset only once.
REQ-033 i_ready low 5 cycles mid-symbol in RUN -> next o_valid delayed exactly 5 cycles; no o_valid while low.
REQ-034 Continuous, 1022 symbols -> o_period with valids 511 and 1022 only; o_sym_count=1022 at end.
REQ-035 i_stop mid-GAP, then i_start+i_stop same cycle -> IDLE, stays IDLE, o_busy=0, o_sym_count held.
REQ-036 i_reset_n low between edges in RUN -> o_enable, o_valid, o_busy, o_sym_count 0 before next edge.
